// File: rtl/dram_read_arbiter_pkg.sv
// Shared widths and FIFO word packing for the DRAM read-address path.
package dram_read_arbiter_pkg;

    localparam int DRAM_ADDR_W   = 24;
    localparam int DRAM_PERIOD_W = 14;
    localparam int FIFO_WORD_W   = 40;

    function automatic logic [FIFO_WORD_W-1:0] pack_fifo_word(
        input logic [DRAM_PERIOD_W-1:0] period,
        input logic [DRAM_ADDR_W-1:0]   addr
    );
        return {2'b00, period, addr};
    endfunction

endpackage

// File: rtl/dram_read_arbiter_if.sv
// Requester handshake plus FIFO sender bus between playback voices and the address FIFO.
interface dram_read_arbiter_if
    import dram_read_arbiter_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = DRAM_ADDR_W
);
    logic [N-1:0]           req_valid;
    logic [ADDR_W-1:0]      req_addr [N];
    logic [N-1:0]           req_ready;
    logic                   m_tvalid;
    logic                   m_tready;
    logic [FIFO_WORD_W-1:0] m_tdata;
    logic                   m_tlast;
    logic                   fifo_prog_full;

    modport master (
        input  req_valid, req_addr, m_tready, fifo_prog_full,
        output req_ready, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        output req_valid, req_addr, m_tready, fifo_prog_full,
        input  req_ready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/dram_read_arbiter_rr.sv
// Round-robin one-hot pick starting at ptr, using a doubled request vector so the
// wrap-around search is a single lowest-set-bit operation.
module rr_priority_select #(
    parameter  int N     = 8,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);
    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        req_dbl = {eligible, eligible & hi_mask};
        gnt_dbl = req_dbl & ~(req_dbl - (2*N)'(1));
        grant   = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) idx = PTR_W'(i);
        end
        any = |eligible;
    end
endmodule

// File: rtl/dram_read_arbiter.sv
// Shares the DRAM read-address FIFO between playback requesters: one grant per
// requester per sample chunk, FIFO backpressure honoured, late requesters flagged.
module dram_read_arbiter
    import dram_read_arbiter_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = 8,
    parameter int ADDR_W           = DRAM_ADDR_W,
    parameter int PERIOD_W         = DRAM_PERIOD_W,
    parameter int PERIOD_RESET     = 2272
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        chunk_start,
    input  logic [PERIOD_W-1:0]         sample_period,
    input  logic                        overrun_clear,
    output logic [INSTRUMENT_COUNT-1:0] overrun,
    output logic                        busy,
    dram_read_arbiter_if.master         bus
);
    localparam int N     = INSTRUMENT_COUNT;
    localparam int PTR_W = $clog2(N);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

    logic [N-1:0]           served;
    logic [PTR_W-1:0]       ptr;
    logic [PERIOD_W-1:0]    period_hold;
    logic                   tvalid_q;
    logic [FIFO_WORD_W-1:0] tdata_q;
    logic                   tlast_q;
    logic [N-1:0]           overrun_q;

    logic [N-1:0]        eligible;
    logic [N-1:0]        grant_onehot;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        ovr_set;
    logic [PTR_W-1:0]    sel;
    logic [PTR_W-1:0]    ptr_next;
    logic [PERIOD_W-1:0] period_next;
    logic                any_eligible;
    logic                slot_free;
    logic                grant_en;
    logic                last_next;

    // At a chunk boundary the served mask is about to clear, so everyone valid is eligible again.
    assign eligible    = bus.req_valid & ~(served & {N{~chunk_start}});
    assign period_next = chunk_start ? sample_period : period_hold;
    assign slot_free   = ~tvalid_q | bus.m_tready;
    assign grant_en    = ~rst & slot_free & ~bus.fifo_prog_full & any_eligible;
    assign req_ready   = grant_en ? grant_onehot : '0;
    assign last_next   = ~|(eligible & ~grant_onehot);
    assign ptr_next    = (sel == LAST_IDX) ? '0 : sel + PTR_W'(1);
    assign ovr_set     = chunk_start ? (bus.req_valid & ~served & ~req_ready) : '0;

    rr_priority_select #(.N(N)) u_select (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant_onehot),
        .idx      (sel),
        .any      (any_eligible)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            served      <= '0;
            ptr         <= '0;
            period_hold <= PERIOD_W'(PERIOD_RESET);
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            overrun_q   <= '0;
        end else begin
            period_hold <= period_next;
            served      <= (chunk_start ? '0 : served) | req_ready;
            overrun_q   <= (overrun_clear ? '0 : overrun_q) | ovr_set;
            if (grant_en) begin
                tvalid_q <= 1'b1;
                tdata_q  <= pack_fifo_word(DRAM_PERIOD_W'(period_next),
                                           DRAM_ADDR_W'(bus.req_addr[sel]));
                tlast_q  <= last_next;
                ptr      <= ptr_next;
            end else if (bus.m_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.m_tvalid  = tvalid_q;
    assign bus.m_tdata   = tdata_q;
    assign bus.m_tlast   = tlast_q;
    assign overrun       = overrun_q;
    assign busy          = |(bus.req_valid & ~served);
endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed scenarios followed by random traffic, checked against a chunk-level model
// of which requesters may still be served and who is next in rotation.
module tb_dram_read_arbiter;
    import dram_read_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int PR = 2272;

    logic         clk = 1'b0;
    logic         rst;
    logic         chunk_start;
    logic [13:0]  sample_period;
    logic         overrun_clear;
    logic [N-1:0] overrun;
    logic         busy;

    dram_read_arbiter_if #(.N(N), .ADDR_W(24)) bus ();

    dram_read_arbiter #(
        .INSTRUMENT_COUNT (N),
        .ADDR_W           (24),
        .PERIOD_W         (14),
        .PERIOD_RESET     (PR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chunk_start   (chunk_start),
        .sample_period (sample_period),
        .overrun_clear (overrun_clear),
        .overrun       (overrun),
        .busy          (busy),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit          m_served [N];
    bit          m_ovr    [N];
    int          m_ptr;
    int          m_period;
    bit          m_tv;
    logic [39:0] m_td;
    bit          m_tl;
    int          glog [$];
    logic [N-1:0] last_ready;
    logic [39:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_served[i] = 0;
            m_ovr[i]    = 0;
        end
        m_ptr = 0; m_period = PR; m_tv = 0; m_td = '0; m_tl = 0;
    endtask

    task automatic set_in(input bit cs, input logic [N-1:0] v, input bit tr, input bit pf, input bit clr);
        chunk_start        = cs;
        bus.req_valid      = v;
        bus.m_tready       = tr;
        bus.fifo_prog_full = pf;
        overrun_clear      = clr;
    endtask

    // One clock: predict grant and busy from the chunk rules, then the registered outputs.
    task automatic cycle();
        int           g;
        int           np;
        bit           elig [N];
        bit           exp_busy;
        logic [N-1:0] exp_ready;
        logic [N-1:0] ovr_v;
        #1;
        g = -1;
        exp_busy = 0;
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.req_valid[i] && !(m_served[i] && !chunk_start);
            if (bus.req_valid[i] && !m_served[i]) exp_busy = 1;
        end
        if (!rst && (!m_tv || bus.m_tready) && !bus.fifo_prog_full) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = (g >= 0) ? N'(1) << g : '0;
        chk("req_ready", bus.req_ready, exp_ready);
        chk("busy", busy, exp_busy);
        last_ready = bus.req_ready;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) glog.push_back(i);
        end
        if (rst) begin
            model_reset();
        end else begin
            np = chunk_start ? int'(sample_period) : m_period;
            for (int i = 0; i < N; i++) begin
                if (overrun_clear) m_ovr[i] = 0;
                if (chunk_start && bus.req_valid[i] && !m_served[i] && i != g) m_ovr[i] = 1;
            end
            if (g >= 0) begin
                m_tv = 1;
                m_td = {2'b00, 14'(np), bus.req_addr[g]};
                m_tl = 1;
                for (int i = 0; i < N; i++) begin
                    if (elig[i] && i != g) m_tl = 0;
                end
                m_ptr = (g + 1) % N;
            end else if (bus.m_tready) begin
                m_tv = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (chunk_start) m_served[i] = 0;
            end
            if (g >= 0) m_served[g] = 1;
            m_period = np;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) ovr_v[i] = m_ovr[i];
        chk("m_tvalid", bus.m_tvalid, m_tv);
        chk("m_tdata", bus.m_tdata, m_td);
        chk("m_tlast", bus.m_tlast, m_tl);
        chk("overrun", overrun, ovr_v);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        sample_period = 14'd0;
        set_in(0, '0, 1, 0, 0);
        for (int i = 0; i < N; i++) bus.req_addr[i] = 24'hA00000 + 24'(i * 24'h111);
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("rst_tvalid", bus.m_tvalid, 1'b0);
        chk("rst_tdata", bus.m_tdata, 40'd0);
        rst = 1'b0;

        // All four valid from a chunk start: 0,1,2,3 back to back, last on 3 only.
        sample_period = 14'd1000;
        set_in(1, 4'b1111, 1, 0, 0);
        cycle();
        chk("s1_period", bus.m_tdata[37:24], 14'd1000);
        chk("s1_last0", bus.m_tlast, 1'b0);
        set_in(0, 4'b1111, 1, 0, 0);
        cycles(2);
        cycle();
        chk("s1_last3", bus.m_tlast, 1'b1);
        cycles(3);
        chk("s1_cnt", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("s1_order", glog[i], i);
        glog.delete();

        // Leave ptr at 2, then 1011 from a new chunk: 3,0,1 and never 2.
        set_in(0, 4'b0000, 1, 0, 0); cycle();
        set_in(1, 4'b0010, 1, 0, 0); cycle();
        set_in(0, 4'b0000, 1, 0, 0); cycle();
        set_in(1, 4'b1011, 1, 0, 0); cycle();
        set_in(0, 4'b1011, 1, 0, 0); cycles(4);
        chk("s2_cnt", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("s2_g0", glog[0], 1);
            chk("s2_g1", glog[1], 3);
            chk("s2_g2", glog[2], 0);
            chk("s2_g3", glog[3], 1);
        end
        glog.delete();

        // Stall five cycles with a word pending; release gives an immediate grant.
        set_in(0, 4'b0000, 1, 0, 0); cycle();
        set_in(1, 4'b0001, 0, 0, 0); cycle();
        held = bus.m_tdata;
        set_in(0, 4'b0110, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("s3_hold", bus.m_tdata, held);
        end
        set_in(0, 4'b0110, 1, 0, 0); cycle();
        chk("s3_release", glog.size(), 2);
        cycle();
        glog.delete();

        // prog_full lets the pending word drain but blocks new grants.
        set_in(0, 4'b1000, 1, 1, 0); cycle();
        chk("s4_drain", bus.m_tvalid, 1'b0);
        cycles(2);
        chk("s4_blocked", glog.size(), 0);
        set_in(0, 4'b1000, 1, 0, 0); cycle();
        chk("s4_grant", glog.size(), 1);
        glog.delete();

        // Overrun: requester 1 starved across a chunk start, then clear, then clear+set.
        set_in(0, 4'b0000, 1, 0, 0); cycle();
        set_in(1, 4'b0001, 1, 0, 1); cycle();
        set_in(0, 4'b0011, 0, 0, 0); cycles(2);
        sample_period = 14'd500;
        set_in(1, 4'b0011, 0, 0, 0); cycle();
        chk("s5_set", overrun, 4'b0010);
        set_in(0, 4'b0000, 0, 0, 1); cycle();
        chk("s5_clear", overrun, 4'b0000);
        set_in(1, 4'b0010, 0, 0, 1); cycle();
        chk("s5_both", overrun, 4'b0010);

        // Reset in the middle of a burst.
        set_in(0, 4'b0000, 1, 0, 0); cycle();
        set_in(1, 4'b1111, 1, 0, 0); cycle();
        set_in(0, 4'b1111, 1, 0, 0); cycle();
        rst = 1'b1; cycle();
        chk("s6_rst_tvalid", bus.m_tvalid, 1'b0);
        chk("s6_rst_ovr", overrun, 4'b0000);
        rst = 1'b0;
        glog.delete();
        cycle();
        chk("s6_first", (glog.size() > 0) ? glog[0] : -1, 0);
        chk("s6_period", bus.m_tdata[37:24], 14'(PR));
        glog.delete();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] v;
            v = bus.req_valid;
            for (int i = 0; i < N; i++) begin
                if (!v[i] || last_ready[i]) begin
                    v[i] = 1'($urandom_range(1));
                    bus.req_addr[i] = 24'($urandom);
                end else if ($urandom_range(9) == 0) begin
                    v[i] = 1'b0;
                end
            end
            sample_period = 14'($urandom);
            rst = ($urandom_range(99) == 0);
            set_in($urandom_range(7) == 0, v, $urandom_range(3) != 0,
                   $urandom_range(5) == 0, $urandom_range(9) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
